// File: rtl/single_port_ram_be.sv
// Single-port synchronous RAM with byte-lane writes, selectable read-during-write
// behaviour, optional output register and a self-scrubbing clear sequencer.
module single_port_ram_be #(
    parameter int                  ADDR_WIDTH   = 14,
    parameter int                  DATA_WIDTH   = 32,
    parameter int                  OUT_REG      = 0,
    parameter int                  READ_MODE    = 0,
    parameter int                  CLEAR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic                      clear_req,
    output logic                      ready,
    input  logic                      req,
    input  logic                      we,
    input  logic [DATA_WIDTH/8-1:0]   byte_en,
    input  logic [ADDR_WIDTH-1:0]     addr,
    input  logic [DATA_WIDTH-1:0]     din,
    output logic [DATA_WIDTH-1:0]     dout,
    output logic                      dout_valid,
    output logic                      clear_busy
);
    localparam int NUM_BYTES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    typedef enum logic {RUN, CLEAR} state_t;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr;
    logic                  rd;
    logic                  last;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [NUM_BYTES-1:0]  mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] old_word;
    logic [DATA_WIDTH-1:0] merged;
    logic                  rd_fire;
    logic [DATA_WIDTH-1:0] rd_word;

    // Reset masks handshake and busy flags in the very cycle it is asserted
    assign ready      = (state == RUN) && !sync_reset;
    assign clear_busy = (state == CLEAR) && !sync_reset;
    assign wr         = req && ready && we;
    assign rd         = req && ready && !we;
    assign last       = &count[ADDR_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= (CLEAR_ON_RST != 0) ? CLEAR : RUN;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        unique case (state)
            RUN: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    count_next = '0;
                end
            end
            CLEAR: begin
                count_next = count + 1'b1;
                if (last) begin
                    state_next = RUN;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        old_word = mem[addr];
        merged   = old_word;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (byte_en[i]) begin
                merged[8*i +: 8] = din[8*i +: 8];
            end
        end
    end

    assign mem_we    = clear_busy || wr;
    assign mem_addr  = clear_busy ? count[ADDR_WIDTH-1:0] : addr;
    assign mem_be    = clear_busy ? '1 : byte_en;
    assign mem_wdata = clear_busy ? CLEAR_VALUE : din;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                if (mem_be[i]) begin
                    mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-through mode returns the merged word of the write itself
    assign rd_fire = rd || ((READ_MODE != 0) && wr);
    assign rd_word = we ? merged : old_word;

    if (OUT_REG == 0) begin : g_direct
        always_ff @(posedge clk) begin
            if (sync_reset) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= rd_fire;
                if (rd_fire) begin
                    dout <= rd_word;
                end
            end
        end
    end else begin : g_piped
        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_data;

        always_ff @(posedge clk) begin
            if (sync_reset) begin
                s1_valid <= 1'b0;
            end else begin
                s1_valid <= rd_fire;
            end
            if (rd_fire) begin
                s1_data <= rd_word;
            end
        end

        always_ff @(posedge clk) begin
            if (sync_reset) begin
                dout       <= '0;
                dout_valid <= 1'b0;
            end else begin
                dout_valid <= s1_valid;
                if (s1_valid) begin
                    dout <= s1_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_single_port_ram_be.sv
// Bench for single_port_ram_be: two configurations (latency 1 / read-first / clear 0
// and latency 2 / write-through / clear all-ones) checked against a scoreboard.
module tb_single_port_ram_be;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
    localparam logic [DW-1:0] CV0 = 32'h0000_0000;
    localparam logic [DW-1:0] CV1 = 32'hFFFF_FFFF;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic          sync_reset [2];
    logic          clear_req  [2];
    logic          ready      [2];
    logic          req        [2];
    logic          we         [2];
    logic [NB-1:0] byte_en    [2];
    logic [AW-1:0] addr       [2];
    logic [DW-1:0] din        [2];
    logic [DW-1:0] dout       [2];
    logic          dout_valid [2];
    logic          clear_busy [2];

    single_port_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(0), .READ_MODE(0),
        .CLEAR_ON_RST(1), .CLEAR_VALUE(CV0)
    ) u_ram0 (
        .clk(clk), .sync_reset(sync_reset[0]), .clear_req(clear_req[0]),
        .ready(ready[0]), .req(req[0]), .we(we[0]), .byte_en(byte_en[0]),
        .addr(addr[0]), .din(din[0]), .dout(dout[0]),
        .dout_valid(dout_valid[0]), .clear_busy(clear_busy[0])
    );

    single_port_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .OUT_REG(1), .READ_MODE(1),
        .CLEAR_ON_RST(1), .CLEAR_VALUE(CV1)
    ) u_ram1 (
        .clk(clk), .sync_reset(sync_reset[1]), .clear_req(clear_req[1]),
        .ready(ready[1]), .req(req[1]), .we(we[1]), .byte_en(byte_en[1]),
        .addr(addr[1]), .din(din[1]), .dout(dout[1]),
        .dout_valid(dout_valid[1]), .clear_busy(clear_busy[1])
    );

    logic [DW-1:0] model [2][DEPTH];
    exp_t q0 [$];
    exp_t q1 [$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    task automatic push(input int i, input logic [DW-1:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic mon(input int i);
        exp_t e;
        if ((i == 0 ? q0.size() : q1.size()) == 0) begin
            check($sformatf("spurious_valid%0d", i), 32'(dout_valid[i]), 32'd0);
        end else begin
            e = (i == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("rd_data%0d", i), dout[i], e.data);
            check($sformatf("rd_cycle%0d", i), cyc, e.cyc);
        end
    endtask

    always @(negedge clk) if (dout_valid[0] === 1'b1) mon(0);
    always @(negedge clk) if (dout_valid[1] === 1'b1) mon(1);

    // Drive one access at a negedge and advance to the next negedge
    task automatic access(input int i, input logic w, input logic [NB-1:0] be,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [DW-1:0] m;
        check($sformatf("ready%0d", i), 32'(ready[i]), 32'd1);
        req[i] = 1'b1; we[i] = w; byte_en[i] = be; addr[i] = a; din[i] = d;
        m = model[i][a];
        for (int b = 0; b < NB; b++) begin
            if (be[b]) m[8*b +: 8] = d[8*b +: 8];
        end
        if (!w) begin
            push(i, model[i][a], cyc + lat(i));
        end else begin
            model[i][a] = m;
            if (i == 1) push(i, m, cyc + lat(i));
        end
        @(negedge clk);
    endtask

    task automatic idle(input int i, input int n);
        req[i] = 1'b0;
        we[i]  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int i, input logic [DW-1:0] cv);
        sync_reset[i] = 1'b1;
        req[i]        = 1'b0;
        clear_req[i]  = 1'b0;
        @(negedge clk);
        check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd0);
        check($sformatf("rst_busy%0d", i), 32'(clear_busy[i]), 32'd0);
        check($sformatf("rst_dout%0d", i), dout[i], 32'd0);
        check($sformatf("rst_valid%0d", i), 32'(dout_valid[i]), 32'd0);
        sync_reset[i] = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[i][a] = cv;
    endtask

    task automatic wait_ready(input int i, input string tag);
        int n;
        n = 0;
        #1;
        while (!ready[i] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, DEPTH);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 2; i++) begin
            sync_reset[i] = 1'b1; clear_req[i] = 1'b0; req[i] = 1'b0;
            we[i] = 1'b0; byte_en[i] = '0; addr[i] = '0; din[i] = '0;
        end
        @(negedge clk);

        // Instance 0: reset clear, full readback, byte merge, random traffic
        do_reset(0, CV0);
        wait_ready(0, "t1_clear_len0");
        for (int a = 0; a < DEPTH; a++) access(0, 1'b0, '0, AW'(a), '0);
        access(0, 1'b1, 4'hF, 4'd5, 32'hDEAD_BEEF);
        access(0, 1'b1, 4'b0101, 4'd5, 32'h1122_3344);
        access(0, 1'b0, '0, 4'd5, '0);
        access(0, 1'b1, 4'h0, 4'd5, 32'hFFFF_FFFF);
        access(0, 1'b0, '0, 4'd5, '0);
        idle(0, 2);
        check("t2_merge", model[0][5], 32'hDE22_BE44);
        for (int k = 0; k < 40; k++) begin
            access(0, 1'($urandom), NB'($urandom), AW'($urandom), $urandom);
        end
        idle(0, 4);

        // Reset in the middle of a clear restarts the sweep
        do_reset(0, CV0);
        repeat (9) @(negedge clk);
        do_reset(0, CV0);
        wait_ready(0, "t5_restart_len");
        access(0, 1'b0, '0, 4'd5, '0);
        access(0, 1'b0, '0, 4'd15, '0);
        idle(0, 3);

        // Instance 1: pipelined reads, write-through, clear on request
        do_reset(1, CV1);
        wait_ready(1, "t1_clear_len1");
        access(1, 1'b0, '0, 4'd0, '0);
        access(1, 1'b1, 4'hF, 4'd1, 32'h0101_0101);
        access(1, 1'b1, 4'hF, 4'd2, 32'h0202_0202);
        access(1, 1'b1, 4'hF, 4'd3, 32'h0303_0303);
        access(1, 1'b0, '0, 4'd1, '0);
        access(1, 1'b0, '0, 4'd2, '0);
        access(1, 1'b0, '0, 4'd3, '0);
        idle(1, 1);
        access(1, 1'b1, 4'hF, 4'd7, 32'hAABB_CCDD);
        access(1, 1'b1, 4'b0001, 4'd7, 32'h0000_0011);
        access(1, 1'b0, '0, 4'd7, '0);
        idle(1, 3);
        check("t4_merge", model[1][7], 32'hAABB_CC11);
        for (int k = 0; k < 30; k++) begin
            access(1, 1'($urandom), NB'($urandom), AW'($urandom), $urandom);
        end
        idle(1, 4);

        // Clear request with a read in the same cycle; writes during clear ignored
        clear_req[1] = 1'b1;
        access(1, 1'b0, '0, 4'd2, '0);
        clear_req[1] = 1'b0;
        for (int a = 0; a < DEPTH; a++) model[1][a] = CV1;
        check("t6_ready_low", 32'(ready[1]), 32'd0);
        req[1] = 1'b1; we[1] = 1'b1; byte_en[1] = 4'hF;
        addr[1] = 4'd3; din[1] = 32'h1234_5678;
        n = 0;
        while (clear_busy[1] && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("t6_busy_len", n, DEPTH);
        idle(1, 0);
        for (int a = 0; a < DEPTH; a++) access(1, 1'b0, '0, AW'(a), '0);
        idle(1, 5);

        check("drain0", q0.size(), 0);
        check("drain1", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
